// File: rtl/ps2_keys_pkg.sv
// ps2_keys_pkg -- shared constants for the PS/2 key tracker.
//   Scan-code bytes (prefixes, special codes, the eight tracked keys),
//   key bit indices into keys_held, the prefix FSM state type and the
//   default prefix timeout.
package ps2_keys_pkg;

    // Prefix and special bytes
    localparam logic [7:0] SC_E0 = 8'hE0;  // extended prefix
    localparam logic [7:0] SC_F0 = 8'hF0;  // break prefix
    localparam logic [7:0] SC_E1 = 8'hE1;  // Pause lead-in, treated as unmapped
    localparam logic [7:0] SC_AA = 8'hAA;  // BAT complete, treated as unmapped

    // Non-extended key codes
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    // Extended (E0-prefixed) key codes
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Bit positions in keys_held / key_press / key_release
    localparam logic [2:0] KEY_W     = 3'd0;
    localparam logic [2:0] KEY_A     = 3'd1;
    localparam logic [2:0] KEY_S     = 3'd2;
    localparam logic [2:0] KEY_D     = 3'd3;
    localparam logic [2:0] KEY_UP    = 3'd4;
    localparam logic [2:0] KEY_LEFT  = 3'd5;
    localparam logic [2:0] KEY_DOWN  = 3'd6;
    localparam logic [2:0] KEY_RIGHT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } ps2_state_e;

    // 50 ms at 50 MHz
    localparam int unsigned TIMEOUT_CYCLES_DEF = 2500000;

endpackage

// File: rtl/ps2_scan_lut.sv
// ps2_scan_lut -- combinational scan-code to key-index lookup.
//   code_i : final scan byte
//   ext_i  : 1 when the byte was preceded by E0
//   hit_o  : 1 when (code_i, ext_i) is one of the tracked keys
//   idx_o  : key bit index, valid when hit_o = 1
module ps2_scan_lut
    import ps2_keys_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       ext_i,
    output logic       hit_o,
    output logic [2:0] idx_o
);

    always_comb begin
        hit_o = 1'b0;
        idx_o = 3'd0;
        if (!ext_i) begin
            case (code_i)
                SC_W:    begin hit_o = 1'b1; idx_o = KEY_W; end
                SC_A:    begin hit_o = 1'b1; idx_o = KEY_A; end
                SC_S:    begin hit_o = 1'b1; idx_o = KEY_S; end
                SC_D:    begin hit_o = 1'b1; idx_o = KEY_D; end
                default: ;
            endcase
        end else begin
            case (code_i)
                SC_UP:    begin hit_o = 1'b1; idx_o = KEY_UP;    end
                SC_LEFT:  begin hit_o = 1'b1; idx_o = KEY_LEFT;  end
                SC_DOWN:  begin hit_o = 1'b1; idx_o = KEY_DOWN;  end
                SC_RIGHT: begin hit_o = 1'b1; idx_o = KEY_RIGHT; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker -- tracks held state of eight PS/2 keys (WASD + arrows).
//   clk, rst_n   : clock, asynchronous active-low reset
//   keycode      : receiver window, only [7:0] (newest byte) is used
//   kc_valid     : one-cycle strobe for a new byte
//   keys_held    : level, one bit per tracked key
//   key_press    : one-cycle pulse on a held bit rising
//   key_release  : one-cycle pulse on a held bit falling
//   seq_err      : one-cycle pulse on prefix timeout or F0-then-E0 order
module ps2_key_tracker
    import ps2_keys_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] keycode,
    input  logic        kc_valid,
    output logic [7:0]  keys_held,
    output logic [7:0]  key_press,
    output logic [7:0]  key_release,
    output logic        seq_err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

    ps2_state_e    state_q;
    logic [CW-1:0] tmo_q;
    logic [7:0]    held_q, press_q, rel_q;
    logic          err_q;

    logic [7:0] code;
    logic       ext_pend, brk_pend;
    logic       lut_hit;
    logic [2:0] lut_idx;
    logic [7:0] unused_hi;

    assign code      = keycode[7:0];
    assign unused_hi = keycode[15:8];
    assign ext_pend  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign brk_pend  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

    ps2_scan_lut u_lut (
        .code_i (code),
        .ext_i  (ext_pend),
        .hit_o  (lut_hit),
        .idx_o  (lut_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            held_q  <= '0;
            press_q <= '0;
            rel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            press_q <= '0;
            rel_q   <= '0;
            err_q   <= 1'b0;
            if (kc_valid) begin
                if (code == SC_E0) begin
                    // E0 always (re)starts an extended sequence; only after F0 is it out of order
                    state_q <= ST_EXT;
                    tmo_q   <= TMO_LOAD;
                    err_q   <= (state_q == ST_BRK);
                end else if (code == SC_F0 && state_q == ST_IDLE) begin
                    state_q <= ST_BRK;
                    tmo_q   <= TMO_LOAD;
                end else if (code == SC_F0 && state_q == ST_EXT) begin
                    state_q <= ST_EXT_BRK;
                    tmo_q   <= TMO_LOAD;
                end else begin
                    // Final byte (a second F0 lands here too and misses the LUT)
                    state_q <= ST_IDLE;
                    tmo_q   <= '0;
                    if (lut_hit) begin
                        // Only real transitions pulse: repeats and stray breaks are dropped
                        if (brk_pend && held_q[lut_idx]) begin
                            held_q[lut_idx] <= 1'b0;
                            rel_q[lut_idx]  <= 1'b1;
                        end else if (!brk_pend && !held_q[lut_idx]) begin
                            held_q[lut_idx]  <= 1'b1;
                            press_q[lut_idx] <= 1'b1;
                        end
                    end
                end
            end else if (state_q != ST_IDLE) begin
                // A byte arriving on the zero cycle wins over the timeout
                if (tmo_q == '0) begin
                    state_q <= ST_IDLE;
                    err_q   <= 1'b1;
                end else begin
                    tmo_q <= tmo_q - CW'(1);
                end
            end
        end
    end

    assign keys_held   = held_q;
    assign key_press   = press_q;
    assign key_release = rel_q;
    assign seq_err     = err_q;

endmodule
